// File: rtl/bin2prio_pkg.sv
// Shared constants and helpers for the bin2prio priority encoder.
// The optional binary index output is enabled by the BIN2PRIO_IDX_EN macro.
package bin2prio_pkg;

  localparam int DEFAULT_DW = 8;

  // Width of the binary index for a DW-bit request vector.
  function automatic int idx_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/bin2prio_core.sv
// Combinational priority encoder: one-hot grant for the highest set bit of in.
// Define BIN2PRIO_IDX_EN to add the binary index output idx.
module bin2prio_core
  import bin2prio_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  localparam int IW = idx_w(DW)
) (
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
`ifdef BIN2PRIO_IDX_EN
  output logic [IW-1:0] idx,
`endif
  output logic          valid
);

  // Scan upward so each higher set bit overrides any lower one.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    out = '0;
`ifdef BIN2PRIO_IDX_EN
    idx = '0;
`endif
    for (int k = 0; k < DW; k++) begin
      if (in[k]) begin
        out    = '0;
        out[k] = 1'b1;
`ifdef BIN2PRIO_IDX_EN
        idx    = IW'(k);
`endif
      end
    end
  end

  assign valid = |in;

endmodule

// File: rtl/bin2prio.sv
// Priority encoder top: bin2prio_core plus a one-cycle registered output stage.
// Define BIN2PRIO_IDX_EN to add idx and its registered copy idx_q.
module bin2prio
  import bin2prio_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  localparam int IW = idx_w(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] out,
  output logic          valid,
`ifdef BIN2PRIO_IDX_EN
  output logic [IW-1:0] idx,
  output logic [IW-1:0] idx_q,
`endif
  output logic [DW-1:0] out_q,
  output logic          valid_q
);

`ifdef BIN2PRIO_IDX_EN
  logic [IW-1:0] idx_d;
`endif

  bin2prio_core #(.DW(DW)) u_core (
    .in    (in),
    .out   (out),
`ifdef BIN2PRIO_IDX_EN
    .idx   (idx_d),
`endif
    .valid (valid)
  );

`ifdef BIN2PRIO_IDX_EN
  assign idx = idx_d;
`endif

  // Reset only clears the register stage; the combinational path ignores rst.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
`ifdef BIN2PRIO_IDX_EN
      idx_q   <= '0;
`endif
    end else begin
      out_q   <= out;
      valid_q <= valid;
`ifdef BIN2PRIO_IDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin2prio.sv
// Self-checking bench for bin2prio: directed cases plus randomized traffic
// compared against an arithmetic reference model (highest power of two <= in).
module tb_bin2prio;

  localparam int DW = 8;
  localparam int IW = $clog2(DW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in  = '0;
  logic [DW-1:0] out, out_q;
  logic          valid, valid_q;
`ifdef BIN2PRIO_IDX_EN
  logic [IW-1:0] idx, idx_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bin2prio #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out),
    .valid   (valid),
`ifdef BIN2PRIO_IDX_EN
    .idx     (idx),
    .idx_q   (idx_q),
`endif
    .out_q   (out_q),
    .valid_q (valid_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (in=%b rst=%b t=%0t)", tag, got, exp, in, rst, $time);
    end
  endtask

  // Reference: index of the highest set bit is floor(log2(v)) = clog2(v+1)-1.
  function automatic int ref_idx(input logic [DW-1:0] v);
    int unsigned x;
    x = 32'(v);
    if (x == 0) return 0;
    return $clog2(x + 1) - 1;
  endfunction

  function automatic logic [DW-1:0] ref_grant(input logic [DW-1:0] v);
    if (v == '0) return '0;
    return DW'(1 << ref_idx(v));
  endfunction

  // Drive one cycle's inputs, check the combinational outputs, then the
  // registered outputs after the following rising edge.
  task automatic apply(input logic [DW-1:0] v, input logic r);
    logic [DW-1:0] eg;
    logic          ev;
    @(negedge clk);
    in  = v;
    rst = r;
    #1;
    eg = ref_grant(v);
    ev = (v != '0);
    check("out",   32'(out),   32'(eg));
    check("valid", 32'(valid), 32'(ev));
`ifdef BIN2PRIO_IDX_EN
    check("idx",   32'(idx),   32'(ref_idx(v)));
`endif
    @(posedge clk);
    #1;
    check("out_q",   32'(out_q),   r ? 32'd0 : 32'(eg));
    check("valid_q", 32'(valid_q), r ? 32'd0 : 32'(ev));
`ifdef BIN2PRIO_IDX_EN
    check("idx_q",   32'(idx_q),   r ? 32'd0 : 32'(ref_idx(v)));
`endif
  endtask

  initial begin
    logic [DW-1:0] v;

    // Reset held for two cycles, then first tracked value.
    apply(8'h00, 1'b1);
    apply(8'h00, 1'b1);
    apply(8'b0000_0110, 1'b0);

    // Walking one.
    for (int i = 0; i < DW; i++) begin
      v = DW'(1 << i);
      apply(v, 1'b0);
    end

    // Multiple bits, zero, all ones, MSB plus LSB.
    apply(8'b0011_0110, 1'b0);
    apply(8'b0000_0000, 1'b0);
    apply(8'b1111_1111, 1'b0);
    apply(8'b1000_0001, 1'b0);
    apply(8'b0000_0001, 1'b0);
    apply(8'b0000_0011, 1'b0);

    // Reset mid-operation: registers clear, combinational path unaffected.
    apply(8'b1100_0000, 1'b1);
    apply(8'b1100_0000, 1'b0);

    // Randomized traffic with occasional reset and sparse patterns.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       v = DW'(1 << $urandom_range(0, DW - 1));
        1:       v = DW'($urandom) & DW'($urandom);
        default: v = DW'($urandom);
      endcase
      apply(v, ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
